serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop, LSB first, WIDTH cycles per operation.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag on ovf_out.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic w_accept;
    logic w_last;
    logic w_bit;
    logic w_carry;

    assign w_accept = (r_state == IDLE) && start_valid;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);

    // The single full-adder cell.
    assign w_bit   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_carry);

    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start_valid) w_next_state = RUN;
            RUN:     if (w_last)      w_next_state = DONE;
            DONE:    if (done_ready)  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The carry register doubles as the carry-out, so it holds the result through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= c_in;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_bit, r_sum[WIDTH-1:1]};
            r_carry <= w_carry;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the final RUN edge r_carry is the carry into the MSB and w_carry the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ovf <= 1'b0;
        else if (w_last) r_ovf <= r_carry ^ w_carry;
    end

    assign ovf_out = r_ovf;
`endif

    assign start_ready = (r_state == IDLE);
    assign done_valid  = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign sum_out     = r_sum;
    assign cout_out    = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver pushes expected results, a negedge monitor pops and compares.
// Define SERIAL_ADDER_OVF_EN for both files to also check ovf_out.
module tb_serial_adder;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH:0] val;
        logic           ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             c_in = 1'b0;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
    logic             done_valid;
    logic             done_ready = 1'b0;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_out;
`endif

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];
    int   acc_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .c_in       (c_in),
        .sum_out    (sum_out),
        .cout_out   (cout_out),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .busy       (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_out    (ovf_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: records accepts, pops on the first DONE cycle, then checks stability while stalled.
    int   nclk = 0;
    bit   seen = 0;
    exp_t cur;
    always @(negedge clk) begin
        nclk++;
        if (!rst_n) begin
            acc_q.delete();
            seen = 0;
        end else begin
            if (start_valid && start_ready) acc_q.push_back(nclk);
            if (done_valid && !seen) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done_valid), 64'(0));
                end else begin
                    cur = exp_q.pop_front();
                    check("sum", 64'(sum_out), 64'(cur.val[WIDTH-1:0]));
                    check("cout", 64'(cout_out), 64'(cur.val[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
                    check("ovf", 64'(ovf_out), 64'(cur.ovf));
`endif
                    if (acc_q.size() == 0) check("latency_no_accept", 64'(0), 64'(1));
                    else check("latency", 64'(nclk - acc_q.pop_front()), 64'(WIDTH + 1));
                end
            end else if (done_valid) begin
                check("hold_sum", 64'(sum_out), 64'(cur.val[WIDTH-1:0]));
                check("hold_cout", 64'(cout_out), 64'(cur.val[WIDTH]));
            end else begin
                seen = 0;
            end
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        exp_t e;
        e.val = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
        e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (e.val[WIDTH-1] != a[WIDTH-1]);
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !start_ready; i++) tick();
        if (!start_ready) check("timeout_start_ready", 64'(start_ready), 64'(1));
    endtask

    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        wait_ready();
        start_valid = 1'b1;
        a_in = a;
        b_in = b;
        c_in = c;
        tick();
        start_valid = 1'b0;
        a_in = WIDTH'($urandom);
        b_in = WIDTH'($urandom);
        c_in = 1'($urandom);
    endtask

    // Driver: one full operation with an optional ignored start pulse and a consumer stall.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input int stall, input bit inject);
        push_exp(a, b, c);
        accept(a, b, c);
        if (inject) begin
            tick();
            tick();
            start_valid = 1'b1;
            a_in = 8'hAA;
            tick();
            start_valid = 1'b0;
        end
        for (int i = 0; i < 50 && !done_valid; i++) tick();
        if (!done_valid) check("timeout_done_valid", 64'(done_valid), 64'(1));
        repeat (stall) tick();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("idle_after_transfer", {62'(0), done_valid, start_ready}, 64'b01);
    endtask

    initial begin
        #3;
        check("reset_outputs", {sum_out, cout_out, done_valid, busy, start_ready},
              {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        tick();
        tick();
        rst_n = 1'b1;

        run_op(8'hFF, 8'h01, 1'b0, 0, 0);   // -> 1_00
        run_op(8'h35, 8'h4A, 1'b1, 0, 0);   // -> 0_80, signed overflow
        run_op(8'h12, 8'h34, 1'b0, 5, 0);   // -> 0_46 held for 5 cycles
        run_op(8'h0F, 8'h01, 1'b0, 1, 1);   // -> 0_10 despite start pulse with AA
        run_op(8'h00, 8'h00, 1'b0, 0, 0);   // -> 0_00
        run_op(8'hFF, 8'hFF, 1'b1, 2, 0);   // -> 1_FF
        run_op(8'h7F, 8'h01, 1'b0, 0, 0);   // -> 0_80, signed overflow

        // Abort in the third RUN cycle; nothing is expected from this operation.
        accept(8'h55, 8'h22, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("reset_mid_run", {sum_out, cout_out, done_valid, busy, start_ready},
              {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        tick();
        rst_n = 1'b1;
        run_op(8'h80, 8'h80, 1'b0, 0, 0);   // -> 1_00

        for (int n = 0; n < 1000; n++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 0);
        end

        tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
